// File: rtl/spi_word_master.sv
// Word-level SPI master (mode 0): pops words from FIFO A, shifts them out MSB-first in one
// chip-select frame per word, and pushes the MISO word captured in that frame into FIFO B.
module spi_word_master #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [WORD_W-1:0] FIFOA_OUT,
  input  logic              FIFOA_empty,
  output logic              FIFOA_ren,
  input  logic              FIFOB_full,
  output logic [WORD_W-1:0] FIFOB_IN,
  output logic              FIFOB_wen,
  output logic              spi_cs,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [7:0]       HalfLast = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BitLast  = BIT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StLoad, StLead, StShift, StTail, StStore, StGap
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        hcnt_q, hcnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WORD_W-1:0] tx_q, tx_d;
  logic [WORD_W-1:0] rx_q, rx_d;
  logic              cs_q, cs_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [WORD_W-1:0] fifob_q, fifob_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hcnt_last;

  assign hcnt_last = (hcnt_q == HalfLast);

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    fifob_d = fifob_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        // FIFO B has a single writer, so a free slot seen here stays free until STORE.
        if (enable && !FIFOA_empty && !FIFOB_full) begin
          state_d = StFetch;
          ren_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StFetch: begin
        state_d = StLoad;
      end
      StLoad: begin
        tx_d    = FIFOA_OUT;
        rx_d    = '0;
        cs_d    = 1'b0;
        mosi_d  = FIFOA_OUT[WORD_W-1];
        hcnt_d  = '0;
        state_d = StLead;
      end
      StLead: begin
        if (hcnt_last) begin
          hcnt_d  = '0;
          sck_d   = 1'b1;
          rx_d    = {rx_q[WORD_W-2:0], spi_miso};
          bit_d   = '0;
          state_d = StShift;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      StShift: begin
        if (!hcnt_last) begin
          hcnt_d = hcnt_q + 8'd1;
        end else begin
          hcnt_d = '0;
          if (sck_q) begin
            // Falling edge: advance MOSI unless this was the last bit.
            sck_d = 1'b0;
            if (bit_q != BitLast) begin
              tx_d   = tx_q << 1;
              mosi_d = tx_q[WORD_W-2];
            end
          end else if (bit_q == BitLast) begin
            state_d = StTail;
          end else begin
            // Rising edge: sample MISO on the same CLK edge that raises SCK.
            sck_d = 1'b1;
            rx_d  = {rx_q[WORD_W-2:0], spi_miso};
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      StTail: begin
        if (hcnt_last) begin
          hcnt_d  = '0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          wen_d   = 1'b1;
          fifob_d = rx_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StStore;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      StStore: begin
        hcnt_d  = '0;
        state_d = StGap;
      end
      StGap: begin
        if (hcnt_last) begin
          hcnt_d  = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      fifob_q <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      fifob_q <= fifob_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign FIFOA_ren = ren_q;
  assign FIFOB_wen = wen_q;
  assign FIFOB_IN  = fifob_q;
  assign spi_cs    = cs_q;
  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;
  assign busy      = busy_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_spi_word_master.sv
// Directed testbench for spi_word_master with small FIFO A / FIFO B models.
`timescale 1ns/1ps
module tb_spi_word_master;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 2;
  localparam int unsigned CW = 16;

  logic          CLK = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [W-1:0]  FIFOA_OUT = '0;
  logic          FIFOA_empty;
  logic          FIFOA_ren;
  logic          FIFOB_full;
  logic [W-1:0]  FIFOB_IN;
  logic          FIFOB_wen;
  logic          spi_cs;
  logic          spi_sck;
  logic          spi_mosi;
  logic          spi_miso;
  logic          busy;
  logic [CW-1:0] frame_cnt;

  logic loop_en;
  logic miso_val;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 CLK = ~CLK;

  assign spi_miso = loop_en ? spi_mosi : miso_val;

  spi_word_master #(.WORD_W(W), .CLK_DIV(D), .CNT_W(CW)) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .enable     (enable),
    .FIFOA_OUT  (FIFOA_OUT),
    .FIFOA_empty(FIFOA_empty),
    .FIFOA_ren  (FIFOA_ren),
    .FIFOB_full (FIFOB_full),
    .FIFOB_IN   (FIFOB_IN),
    .FIFOB_wen  (FIFOB_wen),
    .spi_cs     (spi_cs),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  // FIFO A model: standard mode, data valid the cycle after the read pulse.
  logic [W-1:0] a_mem [16];
  int unsigned  a_wr = 0;
  int unsigned  a_rd = 0;
  assign FIFOA_empty = (a_wr == a_rd);
  always @(posedge CLK) begin
    if (FIFOA_ren) begin
      FIFOA_OUT <= a_mem[a_rd[3:0]];
      a_rd      <= a_rd + 1;
    end
  end

  // FIFO B model: records every written word.
  logic [W-1:0] b_mem [16];
  int unsigned  b_wr = 0;
  always @(posedge CLK) begin
    if (FIFOB_wen) begin
      b_mem[b_wr[3:0]] <= FIFOB_IN;
      b_wr             <= b_wr + 1;
    end
  end

  // Activity monitors sampled on the falling CLK edge.
  int unsigned ren_cnt = 0, rise_cnt = 0, cs_low_cnt = 0, mosi_one_cnt = 0;
  int unsigned falls = 0, high_run = 0;
  int unsigned gap_len [32];
  logic sck_prev = 1'b0, cs_prev = 1'b1;
  always @(negedge CLK) begin
    sck_prev <= spi_sck;
    cs_prev  <= spi_cs;
    if (FIFOA_ren) ren_cnt <= ren_cnt + 1;
    if (spi_sck && !sck_prev) rise_cnt <= rise_cnt + 1;
    if (!spi_cs) begin
      cs_low_cnt <= cs_low_cnt + 1;
      if (spi_mosi) mosi_one_cnt <= mosi_one_cnt + 1;
      if (cs_prev) begin
        gap_len[falls[4:0]] <= high_run;
        falls               <= falls + 1;
        high_run            <= 0;
      end
    end else begin
      high_run <= high_run + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_a(input logic [W-1:0] w);
    a_mem[a_wr[3:0]] = w;
    a_wr = a_wr + 1;
  endtask

  // Wait until FIFO B has received target words and the master has gone idle.
  task automatic wait_frames(input int unsigned target);
    int t;
    t = 0;
    while (b_wr < target && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    check("wen_timeout", (b_wr >= target), 1);
    t = 0;
    while (busy && t < 100) begin
      @(negedge CLK);
      t++;
    end
    check("busy_timeout", busy, 0);
  endtask

  task automatic wait_rises(input int unsigned base, input int unsigned n);
    int t;
    t = 0;
    while ((rise_cnt - base) < n && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    check("rise_timeout", ((rise_cnt - base) >= n), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r0, s0, c0, m0, f;
    int k;
    rst_n      = 1'b0;
    enable     = 1'b0;
    FIFOB_full = 1'b0;
    loop_en    = 1'b1;
    miso_val   = 1'b0;
    cycles(3);

    // Reset values.
    check("rst_cs", spi_cs, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_ren", FIFOA_ren, 0);
    check("rst_wen", FIFOB_wen, 0);
    check("rst_fifob_in", FIFOB_IN, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    cycles(2);

    // Single loopback frame.
    r0 = ren_cnt; s0 = rise_cnt; c0 = cs_low_cnt;
    push_a(32'hA5C3_0F81);
    enable = 1'b1;
    wait_frames(1);
    cycles(2);
    check("lb_ren_count", ren_cnt - r0, 1);
    check("lb_wen_count", b_wr, 1);
    check("lb_word", b_mem[0], 32'hA5C3_0F81);
    check("lb_sck_rises", rise_cnt - s0, 32);
    check("lb_cs_low_cycles", cs_low_cnt - c0, 132);
    check("lb_frame_cnt", frame_cnt, 1);
    check("lb_cs_idle", spi_cs, 1);

    // MISO held high, all-zero word out.
    loop_en = 1'b0; miso_val = 1'b1;
    m0 = mosi_one_cnt;
    push_a(32'h0000_0000);
    wait_frames(2);
    cycles(2);
    check("ones_mosi_high_cycles", mosi_one_cnt - m0, 0);
    check("ones_word", b_mem[1], 32'hFFFF_FFFF);
    check("ones_frame_cnt", frame_cnt, 2);
    loop_en = 1'b1;

    // Three back-to-back loopback frames.
    r0 = ren_cnt;
    push_a(32'h1357_9BDF);
    push_a(32'h8000_0001);
    push_a(32'h7E7E_0FF0);
    wait_frames(5);
    cycles(2);
    f = falls;
    check("b2b_ren_count", ren_cnt - r0, 3);
    check("b2b_word0", b_mem[2], 32'h1357_9BDF);
    check("b2b_word1", b_mem[3], 32'h8000_0001);
    check("b2b_word2", b_mem[4], 32'h7E7E_0FF0);
    check("b2b_frame_cnt", frame_cnt, 5);
    check("b2b_gap1", (gap_len[(f-2) % 32] >= D + 1), 1);
    check("b2b_gap2", (gap_len[(f-1) % 32] >= D + 1), 1);
    check("b2b_busy_end", busy, 0);

    // FIFO B full blocks fetch; release starts a frame within 2 CLK.
    FIFOB_full = 1'b1;
    r0 = ren_cnt; c0 = cs_low_cnt;
    push_a(32'h1234_5678);
    cycles(20);
    check("full_no_ren", ren_cnt - r0, 0);
    check("full_no_cs", cs_low_cnt - c0, 0);
    FIFOB_full = 1'b0;
    k = 0;
    while (!FIFOA_ren && k < 2) begin
      @(negedge CLK);
      k++;
    end
    check("full_release_ren", FIFOA_ren, 1);
    wait_frames(6);
    check("full_word", b_mem[5], 32'h1234_5678);

    // Enable dropped at bit 10 of the first of two queued words.
    enable = 1'b0;
    cycles(2);
    r0 = ren_cnt;
    push_a(32'hCAFE_BABE);
    push_a(32'hDEAD_BEEF);
    s0 = rise_cnt;
    enable = 1'b1;
    wait_rises(s0, 11);
    enable = 1'b0;
    wait_frames(7);
    cycles(20);
    check("en_ren_count", ren_cnt - r0, 1);
    check("en_word", b_mem[6], 32'hCAFE_BABE);
    check("en_wen_total", b_wr, 7);
    check("en_fifoa_not_empty", FIFOA_empty, 0);
    check("en_frame_cnt", frame_cnt, 7);

    // Reset pulsed at bit 20 of the remaining word.
    s0 = rise_cnt;
    enable = 1'b1;
    wait_rises(s0, 21);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs", spi_cs, 1);
    check("mid_rst_sck", spi_sck, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_busy", busy, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    check("mid_rst_no_wen", b_wr, 7);
    check("mid_rst_cs_idle", spi_cs, 1);
    push_a(32'h0F1E_2D3C);
    wait_frames(8);
    check("post_rst_word", b_mem[7], 32'h0F1E_2D3C);
    check("post_rst_frame_cnt", frame_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_word_master.md
Name: spi_word_master

Overview:
- Word-level SPI master between input FIFO A and output FIFO B, clocked by the 6.4 MHz process clock.
- Pops 32-bit words from FIFO A and shifts each one out MSB-first on SPI (mode 0), one chip-select frame per word.
- Captures the MISO word returned in the same frame and pushes it into FIFO B for the host to read back.
- Runs only while `enable` is high (driven from the interface-select and config bits). Exactly one frame is in flight at a time.

Parameters:
- WORD_W, 32: bits per frame and FIFO data width.
- CLK_DIV, 2: SCK half-period in CLK cycles; legal range 1 to 255.
- CNT_W, 16: width of the completed-frame counter.

Ports:
- CLK  input  1  process clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  level; high allows new frames to start.
- FIFOA_OUT  input  WORD_W  FIFO A read data; valid the cycle after FIFOA_ren (standard-mode FIFO).
- FIFOA_empty  input  1  FIFO A empty flag.
- FIFOA_ren  output  1  single-cycle FIFO A read pulse.
- FIFOB_full  input  1  FIFO B full flag.
- FIFOB_IN  output  WORD_W  captured MISO word.
- FIFOB_wen  output  1  single-cycle FIFO B write pulse.
- spi_cs  output  1  active-low chip select.
- spi_sck  output  1  serial clock; idles low.
- spi_mosi  output  1  serial data out.
- spi_miso  input  1  serial data in.
- busy  output  1  high from FIFOA_ren until the end of the CS-high gap.
- frame_cnt  output  CNT_W  number of completed frames.

Behaviour:
- Reset values (asynchronous, take effect immediately, also mid-frame): spi_cs=1, spi_sck=0, spi_mosi=0, FIFOA_ren=0, FIFOB_wen=0, FIFOB_IN=0, busy=0, frame_cnt=0, state=IDLE. After reset, no frame resumes and no partial word is written to FIFO B.
- All outputs are registered.
- FSM states: IDLE, FETCH, LOAD, LEAD, SHIFT, TAIL, STORE, GAP.
- IDLE → FETCH when enable=1, FIFOA_empty=0 and FIFOB_full=0, all sampled in the same cycle.
  - FIFO B fullness is checked only here. FIFO B has a single writer, so the slot stays free and STORE writes unconditionally.
- FETCH (1 cycle): FIFOA_ren=1, busy=1.
- LOAD (1 cycle): tx_shift <= FIFOA_OUT; spi_cs goes to 0 and spi_mosi = FIFOA_OUT[WORD_W-1], both visible from the next cycle.
- LEAD: CLK_DIV cycles with CS low and SCK low.
- SHIFT: WORD_W SCK periods, each CLK_DIV cycles high then CLK_DIV cycles low.
  - On each SCK rising edge (same CLK edge that raises SCK), spi_miso is sampled into rx_shift LSB, shifting left.
  - On each SCK falling edge except the last, MOSI advances to the next lower bit.
  - A half-period counter and a bit counter (0..WORD_W-1) control the state.
- TAIL: CLK_DIV cycles after the last falling edge with SCK low and CS still low; then spi_cs=1.
- STORE (1 cycle): FIFOB_IN <= rx_shift, FIFOB_wen=1, frame_cnt increments. frame_cnt wraps from 2^CNT_W-1 to 0.
- GAP: CS stays high for at least CLK_DIV cycles, then busy=0 and the FSM returns to IDLE.
  - Back-to-back frames therefore have a minimum CS-high time of CLK_DIV+1 cycles.
- Frame timing: CS-low duration is exactly CLK_DIV*(2+2*WORD_W) cycles (132 at defaults).
- enable dropping mid-frame does not abort the frame; the FSM finishes through GAP and then holds in IDLE.
- FIFOA_empty rising during a frame has no effect on that frame; the FSM stops in IDLE afterwards.
- MOSI holds the last bit (bit 0) through TAIL and returns to 0 in STORE.
- CLK_DIV=1 must still produce 50% duty SCK with no skipped edges.

Test Plan:
- Loopback (spi_miso tied to spi_mosi), FIFO A holds 0xA5C3_0F81, enable=1 → one FIFOA_ren pulse; FIFOB_IN=0xA5C3_0F81 with a single FIFOB_wen; 32 SCK rising edges; CS low for exactly 132 CLK; frame_cnt=1.
- spi_miso held at 1, FIFO A holds 0x0000_0000 → MOSI is 0 for the whole frame; FIFO B receives 0xFFFF_FFFF.
- FIFO A holds 3 words, enable=1, loopback → 3 frames with CS high ≥3 CLK between them; FIFO B holds the same 3 words in order; frame_cnt=3; busy=0 after the last GAP.
- FIFOB_full=1 while FIFO A is non-empty → no FIFOA_ren and CS stays high; deasserting full starts a frame within 2 CLK.
- enable deasserted at bit 10 of the first of 2 queued words → first frame completes and is stored; second word is not fetched (FIFOA_ren count=1).
- rst_n pulsed low at bit 20 → same cycle shows spi_cs=1 and spi_sck=0; no FIFOB_wen; frame_cnt=0; after release with enable=1, the next FIFO A word transfers normally.
